mips32_boot_loader: RTL

Parametrised program loader and run supervisor for the mips32 pipeline. It accepts a valid/ready word stream of segment headers and payload words and writes them into instruction memory (Mem_C) or data memory (Mem_D). It then releases the core and counts cycles until the core halts or a programmable cycle limit expires. This replaces hand-poked memory preloads and fixed-delay stop times with a reusable, synthesizable block between the host/bench and the core.

---
 rtl/mips32_pkg.sv | 28 ++
 rtl/mips32_cycle_watchdog.sv | 35 +++
 rtl/mips32_boot_loader.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mips32_pkg.sv
// Shared types and header field layout for the mips32 program loader.
// Stream headers carry LAST, TGT, COUNT and BASE in one word.
package mips32_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      DATA,
      RUN,
      DONE
   } state_t;

   localparam int LAST_BIT = 31;
   localparam int TGT_BIT  = 30;
   localparam int CNT_MSB  = 29;
   localparam int CNT_LSB  = 16;
   localparam int CNT_W    = CNT_MSB - CNT_LSB + 1;

   localparam logic TGT_IMEM = 1'b0;
   localparam logic TGT_DMEM = 1'b1;

   function automatic logic [CNT_W-1:0] hdr_count(
      input logic [31:0] w
   );
      return w[CNT_MSB:CNT_LSB];
   endfunction

endpackage

// File: rtl/mips32_cycle_watchdog.sv
// RUN-cycle counter with optional limit; a halt in the same cycle
// as the limit wins, so expire without timed_out means a clean halt.
module mips32_cycle_watchdog #(
   parameter int CYCLE_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               enable,
   input  logic [CYCLE_W-1:0] limit,
   input  logic               halted,
   output logic [CYCLE_W-1:0] count,
   output logic               expire,
   output logic               timed_out
);

   logic [CYCLE_W-1:0] count_inc;
   logic               limit_hit;

   assign count_inc = count + CYCLE_W'(1);
   assign limit_hit = enable && (limit != '0) && (count_inc == limit);
   assign expire    = enable && (halted || limit_hit);
   assign timed_out = limit_hit && !halted;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != '1)) begin
         count <= count_inc;
      end
   end

endmodule

// File: rtl/mips32_boot_loader.sv
// Streams header/payload words into imem or dmem, then runs the core
// under a cycle watchdog until it halts or the limit expires.
module mips32_boot_loader
   import mips32_pkg::*;
#(
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 32,
   parameter int CYCLE_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [DATA_W-1:0]  s_data,
   output logic               imem_we,
   output logic               dmem_we,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [DATA_W-1:0]  mem_wdata,
   output logic               cpu_run,
   input  logic               cpu_halted,
   input  logic [CYCLE_W-1:0] cycle_limit,
   output logic [CYCLE_W-1:0] cycles,
   output logic               done,
   output logic               timeout,
   output logic               err
);

   localparam int SUM_W = ((ADDR_W > CNT_W) ? ADDR_W : CNT_W) + 1;

   state_t state, state_nx;

   logic              tgt_q;
   logic              last_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  idx_q;
   logic [ADDR_W-1:0] ptr_q;

   logic              start_ok;
   logic              last_word;
   logic [CNT_W-1:0]  hdr_cnt;
   logic [ADDR_W-1:0] hdr_base;
   logic [SUM_W-1:0]  hdr_span;
   logic              hdr_wraps;
   logic              expire;
   logic              timed_out;
   logic              unused_data;

   assign start_ok  = start && ((state == IDLE) || (state == DONE));
   assign last_word = (idx_q + CNT_W'(1)) == cnt_q;
   assign hdr_cnt   = hdr_count(s_data[31:0]);
   assign hdr_base  = s_data[ADDR_W-1:0];
   assign hdr_span  = SUM_W'(hdr_base) + SUM_W'(hdr_cnt);
   assign hdr_wraps = hdr_span > (SUM_W'(1) << ADDR_W);
   assign unused_data = ^s_data;

   mips32_cycle_watchdog #(
      .CYCLE_W(CYCLE_W)
   ) u_wdog (
      .clk      (clk),
      .rst      (rst),
      .clear    (start_ok),
      .enable   (state == RUN),
      .limit    (cycle_limit),
      .halted   (cpu_halted),
      .count    (cycles),
      .expire   (expire),
      .timed_out(timed_out)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      s_ready  = 1'b0;
      cpu_run  = 1'b0;
      done     = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) state_nx = HDR;
         end
         HDR: begin
            s_ready = 1'b1;
            if (s_valid) begin
               if (hdr_cnt != '0) begin
                  state_nx = DATA;
               end else if (s_data[LAST_BIT]) begin
                  state_nx = RUN;
               end
            end
         end
         DATA: begin
            s_ready = 1'b1;
            if (s_valid && last_word) begin
               state_nx = last_q ? RUN : HDR;
            end
         end
         RUN: begin
            cpu_run = 1'b1;
            if (expire) state_nx = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) state_nx = HDR;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Write port is registered so strobes never depend on s_valid
   // combinationally; address and data hold between writes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tgt_q     <= TGT_IMEM;
         last_q    <= 1'b0;
         cnt_q     <= '0;
         idx_q     <= '0;
         ptr_q     <= '0;
         imem_we   <= 1'b0;
         dmem_we   <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         timeout   <= 1'b0;
         err       <= 1'b0;
      end else begin
         imem_we <= 1'b0;
         dmem_we <= 1'b0;
         if (start_ok) begin
            timeout <= 1'b0;
            err     <= 1'b0;
         end
         if ((state == HDR) && s_valid) begin
            tgt_q  <= s_data[TGT_BIT];
            last_q <= s_data[LAST_BIT];
            cnt_q  <= hdr_cnt;
            ptr_q  <= hdr_base;
            idx_q  <= '0;
            if (hdr_wraps) err <= 1'b1;
         end
         if ((state == DATA) && s_valid) begin
            imem_we   <= (tgt_q == TGT_IMEM);
            dmem_we   <= (tgt_q == TGT_DMEM);
            mem_addr  <= ptr_q;
            mem_wdata <= s_data;
            ptr_q     <= ptr_q + ADDR_W'(1);
            idx_q     <= idx_q + CNT_W'(1);
         end
         if ((state == RUN) && expire) begin
            timeout <= timed_out;
         end
      end
   end

endmodule
